// File: rtl/shift_seq_pkg.sv
// Shared types and default sizes for the shift-register command sequencer.
package shift_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_ROTR = 2'd1,
        OP_ROTL = 2'd2,
        OP_ASR  = 2'd3
    } op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shift_next_value.sv
// Value the downstream register holds after one shift of the given kind (bit 0 = LSB).
module shift_next_value
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = value_i;
        case (op_e'(op_i))
            OP_ROTR: next_o = {value_i[0], value_i[WIDTH-1:1]};
            OP_ROTL: next_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
            OP_ASR:  next_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
            default: next_o = value_i;
        endcase
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Sequences load/rotate/arithmetic-shift commands into the 4-bit register stage and
// tracks a shadow of its contents so the stage can be held by reloading while idle.
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             ParallelLoadn,
    output logic             RotateRight,
    output logic             ASRight,
    output logic [WIDTH-1:0] Data_OUT,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and the fields are sampled only at that edge.

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] shadow_d;

    shift_next_value #(.WIDTH(WIDTH)) u_next (
        .value_i (shadow_q),
        .op_i    (op_q),
        .next_o  (shadow_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            op_q     <= OP_LOAD;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (op_e'(cmd_op) == OP_LOAD) begin
                            shadow_q <= cmd_data;
                            done_q   <= 1'b1;
                        end else if (cmd_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            op_q    <= op_e'(cmd_op);
                            cnt_q   <= cmd_count;
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    // Shadow moves in lock-step with the downstream shift on this edge.
                    shadow_q <= shadow_d;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q == S_SHIFT);
    assign ParallelLoadn = busy;
    assign RotateRight   = busy && (op_q != OP_ROTL);
    assign ASRight       = busy && (op_q == OP_ASR);
    assign Data_OUT      = shadow_q;
    assign done          = done_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed table plus randomized commands for shift_cmd_sequencer, with a model of
// the downstream register driven from the sequencer's control outputs.
module tb_shift_cmd_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [W-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          cmd_ready, ParallelLoadn, RotateRight, ASRight, busy, done;
    logic [W-1:0]  Data_OUT, shadow_q;

    shift_cmd_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_count     (cmd_count),
        .ParallelLoadn (ParallelLoadn),
        .RotateRight   (RotateRight),
        .ASRight       (ASRight),
        .Data_OUT      (Data_OUT),
        .busy          (busy),
        .done          (done),
        .shadow_q      (shadow_q)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_shadow = '0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] q_model;

    // Behavioural downstream register: loads when ParallelLoadn=0, otherwise shifts.
    always @(posedge clock) begin
        if (reset)                q_model <= '0;
        else if (!ParallelLoadn)  q_model <= Data_OUT;
        else if (ASRight)         q_model <= {q_model[W-1], q_model[W-1:1]};
        else if (RotateRight)     q_model <= {q_model[0], q_model[W-1:1]};
        else                      q_model <= {q_model[W-2:0], q_model[W-1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference shift computed with integer arithmetic.
    function automatic logic [W-1:0] ref_next(input logic [1:0] op, input logic [W-1:0] s);
        int v    = int'(s);
        int msb  = 1 << (W - 1);
        int mask = (1 << W) - 1;
        case (op)
            2'd1:    return W'(((v >> 1) | ((v & 1) * msb)) & mask);
            2'd2:    return W'(((v << 1) & mask) | (v >> (W - 1)));
            2'd3:    return W'((v >> 1) | (v & msb));
            default: return s;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_pln", ParallelLoadn, 0);
            check("idle_ctl", {RotateRight, ASRight, busy, done}, 4'b0000);
            check("idle_ready", cmd_ready, 1);
            check("idle_data_out", Data_OUT, exp_shadow);
            check("idle_shadow", shadow_q, exp_shadow);
            check("idle_q_model", q_model, exp_shadow);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [CW-1:0] count);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        check("ready_at_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = W'($urandom_range(0, 15));
        cmd_count = CW'($urandom_range(0, 7));
        if (op == 2'd0) begin
            exp_shadow = data;
            check("load_done", done, 1);
            check("load_busy", busy, 0);
            check("load_shadow", shadow_q, exp_shadow);
        end else if (count == '0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_shadow", shadow_q, exp_shadow);
        end else begin
            for (int k = 0; k < int'(count); k++) begin
                exp_shadow = ref_next(op, exp_shadow);
                exp_q.push_back(exp_shadow);
            end
            for (int k = 0; k < int'(count); k++) begin
                check("shift_busy", {busy, cmd_ready, ParallelLoadn, done}, 4'b1010);
                check("shift_rotr", RotateRight, (op != 2'd2));
                check("shift_asr", ASRight, (op == 2'd3));
                step();
                check("shift_shadow", shadow_q, exp_q.pop_front());
            end
            check("shift_end_busy", busy, 0);
            check("shift_done", done, 1);
            check("shift_q_model", q_model, exp_shadow);
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  data;
        logic [CW-1:0] count;
        logic [W-1:0]  exp_final;
        int            idle_after;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{2'd0, 4'b1011, 3'd0, 4'b1011, 10};
        vecs[1] = '{2'd1, 4'b0000, 3'd3, 4'b0111, 2};
        vecs[2] = '{2'd0, 4'b1000, 3'd0, 4'b1000, 1};
        vecs[3] = '{2'd3, 4'b0000, 3'd2, 4'b1110, 0};
        vecs[4] = '{2'd2, 4'b0000, 3'd1, 4'b1101, 1};
        vecs[5] = '{2'd1, 4'b0000, 3'd0, 4'b1101, 1};
        vecs[6] = '{2'd3, 4'b0000, 3'd3, 4'b1111, 1};
        vecs[7] = '{2'd0, 4'b0110, 3'd0, 4'b0110, 0};
        vecs[8] = '{2'd2, 4'b0000, 3'd7, 4'b0011, 2};

        // Clock/reset.
        reset = 1'b1;
        repeat (3) step();
        check("rst_ready", cmd_ready, 1);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_shadow", shadow_q, 0);
        reset = 1'b0;
        exp_shadow = '0;
        idle(5);

        // Directed table.
        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].count);
            check("table_final", shadow_q, vecs[i].exp_final);
            idle(vecs[i].idle_after);
        end

        // Reset in the 2nd SHIFT cycle aborts with no done pulse.
        run_cmd(2'd0, 4'b0001, '0);
        idle(1);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 3'd5; cmd_data = '0;
        step();
        cmd_valid = 1'b0;
        check("abort_busy", busy, 1);
        step();
        check("abort_first_shift", shadow_q, 4'b0010);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_idle", {busy, cmd_ready, done}, 3'b010);
        check("abort_shadow", shadow_q, 0);
        exp_shadow = '0;
        idle(2);

        // cmd_valid held through SHIFT: next command waits for busy to fall.
        run_cmd(2'd0, 4'b0001, '0);
        idle(1);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 3'd3; cmd_data = '0;
        step();
        cmd_op = 2'd0; cmd_data = 4'b1010; cmd_count = 3'd7;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        for (int k = 0; k < 3; k++) begin
            check("held_busy", {busy, cmd_ready}, 2'b10);
            step();
            check("held_shadow", shadow_q, exp_q.pop_front());
        end
        check("held_done", {busy, done}, 2'b01);
        step();
        cmd_valid = 1'b0;
        check("held_b2b_done", done, 1);
        check("held_load", shadow_q, 4'b1010);
        exp_shadow = 4'b1010;
        idle(3);

        // Randomized commands against the arithmetic reference.
        for (int n = 0; n < 40; n++) begin
            run_cmd(2'($urandom_range(0, 3)), W'($urandom_range(0, 15)), CW'($urandom_range(0, 7)));
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
